// File: rtl/cam_line_packer_if.sv
// Output pixel stream of cam_line_packer: FWFT head word plus frame/line position tags.
interface cam_line_packer_if;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic [15:0] m_line_idx;
    logic [15:0] m_frame_idx;

    modport master (
        output m_valid, m_data, m_sof, m_eol, m_line_idx, m_frame_idx,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_sof, m_eol, m_line_idx, m_frame_idx,
        output m_ready
    );
endinterface

// File: rtl/cam_line_packer.sv
// Tags camera pixels with frame-start / end-of-line markers and buffers them in a FWFT FIFO
// feeding a valid/ready stream with per-word line and frame indices.
module cam_line_packer #(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned FIFO_DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cam_init_done,
    input  logic                     vsync,
    input  logic                     de,
    input  logic [15:0]              pix_data,
    cam_line_packer_if.master        m,
    output logic                     err_line_len,
    output logic                     overflow
);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_INIT, WAIT_VS, ACTIVE, DROP} state_t;
    state_t state, state_nxt;

    logic              vsync_q, de_q, vs_rise, de_fall;
    logic              hold_vld;
    logic [15:0]       hold_data;
    logic [15:0]       in_line, pix_cnt;
    logic              sof_pend;
    logic [ADDR_W:0]   wptr, rptr, count;
    logic [17:0]       mem [FIFO_DEPTH];
    logic [17:0]       head;
    logic              full, line_ok;
    logic              wr_req, wr_eol, wr_en, rd_en;
    logic              capture, hold_clear, pix_clr, line_done, frame_start;
    logic [15:0]       line_cnt, frame_cnt;
    logic              seen_sof;

    assign vs_rise = vsync & ~vsync_q;
    assign de_fall = ~de & de_q;
    assign count   = wptr - rptr;
    assign full    = (count == (ADDR_W + 1)'(FIFO_DEPTH));
    assign line_ok = (in_line < 16'(V_ACTIVE));
    assign wr_en   = wr_req & ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        wr_req      = 1'b0;
        wr_eol      = 1'b0;
        capture     = 1'b0;
        hold_clear  = 1'b0;
        pix_clr     = 1'b0;
        line_done   = 1'b0;
        frame_start = 1'b0;
        if (!cam_init_done) begin
            state_nxt  = WAIT_INIT;
            hold_clear = 1'b1;
        end else begin
            case (state)
                WAIT_INIT: state_nxt = WAIT_VS;
                WAIT_VS, DROP: begin
                    if (vs_rise) begin
                        state_nxt   = ACTIVE;
                        frame_start = 1'b1;
                        pix_clr     = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        wr_req      = hold_vld;
                        wr_eol      = 1'b1;
                        hold_clear  = 1'b1;
                        frame_start = 1'b1;
                        pix_clr     = 1'b1;
                    end else if (de_fall) begin
                        wr_req     = hold_vld;
                        wr_eol     = 1'b1;
                        hold_clear = 1'b1;
                        pix_clr    = 1'b1;
                        line_done  = line_ok;
                    end else if (de && line_ok) begin
                        wr_req  = hold_vld;
                        capture = 1'b1;
                    end
                    // A rejected write abandons the rest of the frame, including the pixel in flight.
                    if (wr_req && full) begin
                        state_nxt  = DROP;
                        hold_clear = 1'b1;
                        capture    = 1'b0;
                    end
                end
                default: state_nxt = WAIT_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            hold_vld     <= 1'b0;
            hold_data    <= '0;
            in_line      <= '0;
            pix_cnt      <= '0;
            sof_pend     <= 1'b0;
            err_line_len <= 1'b0;
            overflow     <= 1'b0;
            wptr         <= '0;
        end else begin
            vsync_q      <= vsync;
            de_q         <= de;
            err_line_len <= line_done && (pix_cnt != 16'(H_ACTIVE));
            if (hold_clear) hold_vld <= 1'b0;
            if (capture) begin
                hold_vld  <= 1'b1;
                hold_data <= pix_data;
            end
            if (pix_clr)      pix_cnt <= '0;
            else if (capture) pix_cnt <= pix_cnt + 16'd1;
            if (frame_start)    in_line <= '0;
            else if (line_done) in_line <= in_line + 16'd1;
            // A flushed word on a vsync edge belongs to the old frame, so the new sof request wins.
            if (frame_start)  sof_pend <= 1'b1;
            else if (wr_en)   sof_pend <= 1'b0;
            if (wr_req && full) overflow <= 1'b1;
            if (wr_en) wptr <= wptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[ADDR_W-1:0]] <= {sof_pend, wr_eol, hold_data};
    end

    assign head      = mem[rptr[ADDR_W-1:0]];
    assign m.m_valid = (count != '0);
    assign m.m_data  = m.m_valid ? head[15:0] : '0;
    assign m.m_sof   = m.m_valid & head[17];
    assign m.m_eol   = m.m_valid & head[16];
    assign rd_en     = m.m_valid & m.m_ready;

    // Indices describe the head word itself, so a sof head already shows its new line/frame numbers.
    assign m.m_line_idx  = m.m_sof ? '0 : line_cnt;
    assign m.m_frame_idx = (m.m_sof && seen_sof) ? frame_cnt + 16'd1 : frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr      <= '0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            seen_sof  <= 1'b0;
        end else if (rd_en) begin
            rptr <= rptr + 1'b1;
            if (m.m_sof) begin
                line_cnt <= '0;
                if (seen_sof) frame_cnt <= frame_cnt + 16'd1;
                else          seen_sof  <= 1'b1;
            end else if (m.m_eol) begin
                line_cnt <= line_cnt + 16'd1;
            end
        end
    end
endmodule
